// File: rtl/modo_de_jogo_ctrl.sv
// Game-mode selection controller: steps through the four modes, blinks the digit while a
// choice is pending, pulses start on confirm and locks the mode until game_over.
// Optional idle auto-confirm is enabled with `define MODO_AUTO_CONFIRM_EN.
module modo_de_jogo_ctrl #(
    parameter int BLINK_DIV = 25000000,
    parameter int TIMEOUT   = 250000000,
    parameter int CW        = 28
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_next,
    input  logic       btn_confirm,
    input  logic       game_over,
    output logic [1:0] mode,
    output logic       disp_en,
    output logic       locked,
    output logic       start
);

    if (BLINK_DIV < 2 || TIMEOUT < 2) begin : g_bad_param
        $error("modo_de_jogo_ctrl: BLINK_DIV and TIMEOUT must be >= 2");
    end

    typedef enum logic [1:0] {
        SELECT = 2'b00,
        START  = 2'b01,
        PLAY   = 2'b10
    } state_t;

    state_t        state, state_nx;
    logic [1:0]    mode_nx;
    logic          disp_nx;
    logic [CW-1:0] blink_cnt, blink_nx;
    logic          prev_next, prev_conf;
    logic          edge_next, edge_conf;
    logic          auto_fire;

    assign edge_next = btn_next & ~prev_next;
    assign edge_conf = btn_confirm & ~prev_conf;

`ifdef MODO_AUTO_CONFIRM_EN
    logic [CW-1:0] idle_cnt, idle_nx;
    // A timeout only stands in for a confirm when the player did nothing that cycle.
    assign auto_fire = ~edge_next & ~edge_conf & (idle_cnt == CW'(TIMEOUT - 1));
`else
    assign auto_fire = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        mode_nx  = mode;
        disp_nx  = 1'b1;
        blink_nx = '0;
`ifdef MODO_AUTO_CONFIRM_EN
        idle_nx  = '0;
`endif
        case (state)
            SELECT: begin
                if (edge_conf || auto_fire) begin
                    state_nx = START;
                end else if (edge_next) begin
                    mode_nx = mode + 2'd1;
                end else begin
                    if (blink_cnt == CW'(BLINK_DIV - 1)) begin
                        blink_nx = '0;
                        disp_nx  = ~disp_en;
                    end else begin
                        blink_nx = blink_cnt + 1'b1;
                        disp_nx  = disp_en;
                    end
`ifdef MODO_AUTO_CONFIRM_EN
                    idle_nx = idle_cnt + 1'b1;
`endif
                end
            end
            START: state_nx = PLAY;
            PLAY: begin
                if (game_over) state_nx = SELECT;
            end
            default: begin
                state_nx = SELECT;
                mode_nx  = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= SELECT;
            mode      <= 2'b00;
            disp_en   <= 1'b1;
            locked    <= 1'b0;
            start     <= 1'b0;
            blink_cnt <= '0;
            prev_next <= 1'b1;
            prev_conf <= 1'b1;
`ifdef MODO_AUTO_CONFIRM_EN
            idle_cnt  <= '0;
`endif
        end else begin
            state     <= state_nx;
            mode      <= mode_nx;
            disp_en   <= disp_nx;
            locked    <= (state_nx != SELECT);
            start     <= (state_nx == START);
            blink_cnt <= blink_nx;
            prev_next <= btn_next;
            prev_conf <= btn_confirm;
`ifdef MODO_AUTO_CONFIRM_EN
            idle_cnt  <= idle_nx;
`endif
        end
    end

endmodule

// File: tb/tb_modo_de_jogo_ctrl.sv
// Bench for modo_de_jogo_ctrl: vector table, hand-written corner sequences and random
// stimulus checked against a cycle-count based reference model.
module tb_modo_de_jogo_ctrl;

    localparam int BLINK_DIV = 4;
    localparam int TIMEOUT   = 8;
`ifdef MODO_AUTO_CONFIRM_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset, btn_next, btn_confirm, game_over;
    logic [1:0] mode;
    logic       disp_en, locked, start;

    int checks = 0;
    int errors = 0;

    modo_de_jogo_ctrl #(.BLINK_DIV(BLINK_DIV), .TIMEOUT(TIMEOUT), .CW(8)) dut (
        .clk(clk), .reset(reset), .btn_next(btn_next), .btn_confirm(btn_confirm),
        .game_over(game_over), .mode(mode), .disp_en(disp_en), .locked(locked), .start(start)
    );

    always #5 clk = ~clk;

    // Reference model: phase 0=selecting, 1=start cycle, 2=playing.
    // since_show = cycles since the digit was last (re)shown steadily,
    // since_act  = cycles in selection without any button edge.
    int m_phase, m_mode, since_show, since_act;
    bit m_pn, m_pc;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit n, input bit c, input bit g);
        bit en, ec, fire;
        if (r) begin
            m_phase = 0; m_mode = 0; since_show = 0; since_act = 0; m_pn = 1; m_pc = 1;
            return;
        end
        en = n && !m_pn;
        ec = c && !m_pc;
        m_pn = n;
        m_pc = c;
        case (m_phase)
            0: begin
                fire = ec || (AUTO && !en && since_act == TIMEOUT - 1);
                if (fire) begin
                    m_phase = 1; since_show = 0; since_act = 0;
                end else if (en) begin
                    m_mode = (m_mode + 1) % 4; since_show = 0; since_act = 0;
                end else begin
                    since_show++; since_act++;
                end
            end
            1: m_phase = 2;
            default: if (g) begin
                m_phase = 0; since_show = 0; since_act = 0;
            end
        endcase
    endtask

    task automatic cycle(input bit r, input bit n, input bit c, input bit g);
        @(negedge clk);
        reset = r; btn_next = n; btn_confirm = c; game_over = g;
        @(posedge clk);
        model_step(r, n, c, g);
        #1;
        check("model_mode",   int'(mode),    m_mode);
        check("model_locked", int'(locked),  int'(m_phase != 0));
        check("model_start",  int'(start),   int'(m_phase == 1));
        check("model_disp",   int'(disp_en), int'(m_phase != 0 || ((since_show / BLINK_DIV) % 2) == 0));
    endtask

    typedef struct {
        bit r, n, c, g;
        int mode;
        bit lk, st, de;
    } vec_t;

    vec_t tbl[32];
    int   starts, start_mode;
    bit   rn, rc;

    initial begin
        reset = 1'b1; btn_next = 1'b0; btn_confirm = 1'b0; game_over = 1'b0;

        // Stepping, confirm at 10, locked play, game_over, blink, simultaneous next+confirm at 01.
        tbl[0]  = '{1,0,0,0, 0,0,0,1};
        tbl[1]  = '{0,0,0,0, 0,0,0,1};
        tbl[2]  = '{0,1,0,0, 1,0,0,1};
        tbl[3]  = '{0,0,0,0, 1,0,0,1};
        tbl[4]  = '{0,1,0,0, 2,0,0,1};
        tbl[5]  = '{0,0,0,0, 2,0,0,1};
        tbl[6]  = '{0,1,0,0, 3,0,0,1};
        tbl[7]  = '{0,0,0,0, 3,0,0,1};
        tbl[8]  = '{0,1,0,0, 0,0,0,1};
        tbl[9]  = '{0,0,0,0, 0,0,0,1};
        tbl[10] = '{0,1,0,0, 1,0,0,1};
        tbl[11] = '{0,0,0,0, 1,0,0,1};
        tbl[12] = '{0,1,0,0, 2,0,0,1};
        tbl[13] = '{0,0,0,0, 2,0,0,1};
        tbl[14] = '{0,0,1,0, 2,1,1,1};
        tbl[15] = '{0,1,0,0, 2,1,0,1};
        tbl[16] = '{0,0,1,0, 2,1,0,1};
        tbl[17] = '{0,0,0,0, 2,1,0,1};
        tbl[18] = '{0,0,0,1, 2,0,0,1};
        tbl[19] = '{0,0,0,0, 2,0,0,1};
        tbl[20] = '{0,0,0,0, 2,0,0,1};
        tbl[21] = '{0,0,0,0, 2,0,0,1};
        tbl[22] = '{0,0,0,0, 2,0,0,0};
        tbl[23] = '{0,1,0,0, 3,0,0,1};
        tbl[24] = '{0,0,0,0, 3,0,0,1};
        tbl[25] = '{0,1,0,0, 0,0,0,1};
        tbl[26] = '{0,0,0,0, 0,0,0,1};
        tbl[27] = '{0,1,0,0, 1,0,0,1};
        tbl[28] = '{0,0,0,0, 1,0,0,1};
        tbl[29] = '{0,1,1,0, 1,1,1,1};
        tbl[30] = '{0,0,0,0, 1,1,0,1};
        tbl[31] = '{0,0,0,1, 1,0,0,1};

        foreach (tbl[i]) begin
            cycle(tbl[i].r, tbl[i].n, tbl[i].c, tbl[i].g);
            check($sformatf("tbl_mode[%0d]", i),   int'(mode),    tbl[i].mode);
            check($sformatf("tbl_locked[%0d]", i), int'(locked),  int'(tbl[i].lk));
            check($sformatf("tbl_start[%0d]", i),  int'(start),   int'(tbl[i].st));
            check($sformatf("tbl_disp[%0d]", i),   int'(disp_en), int'(tbl[i].de));
        end

        // Button held through reset release gives no edge until pressed again.
        cycle(1, 1, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0);
        check("held_next_no_step", int'(mode), 0);
        cycle(0, 0, 0, 0);
        cycle(0, 1, 0, 0);
        check("repress_steps", int'(mode), 1);

        // Reset during START suppresses the start pulse.
        cycle(0, 0, 0, 0);
        cycle(0, 0, 1, 0);
        check("start_before_reset", int'(start), 1);
        cycle(1, 0, 0, 0);
        check("reset_in_start_pulse", int'(start), 0);
        check("reset_in_start_mode", int'(mode), 0);
        cycle(0, 0, 0, 0);
        check("reset_in_start_no_late", int'(start), 0);

        // Long idle at mode 11: auto-confirm starts once, otherwise stays selecting.
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1, 0, 0);
            cycle(0, 0, 0, 0);
        end
        starts = 0; start_mode = -1;
        for (int i = 0; i < 100; i++) begin
            cycle(0, 0, 0, 0);
            if (start) begin starts++; start_mode = mode; end
        end
        check("idle100_starts", starts, AUTO ? 1 : 0);
        check("idle100_locked", int'(locked), AUTO ? 1 : 0);
        if (AUTO) check("idle100_start_mode", start_mode, 3);

        // A next press restarts the idle count.
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0);
        cycle(0, 1, 0, 0);
        starts = 0;
        for (int i = 0; i < 7; i++) begin
            cycle(0, 0, 0, 0);
            if (start) starts++;
        end
        check("idle_restart_early", starts, 0);
        cycle(0, 0, 0, 0);
        check("idle_restart_fire", int'(start), AUTO ? 1 : 0);
        check("idle_restart_mode", int'(mode), 1);

        // Random traffic against the model.
        cycle(1, 0, 0, 0);
        rn = 0; rc = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(2, 0) == 0) rn = ~rn;
            if ($urandom_range(5, 0) == 0) rc = ~rc;
            cycle($urandom_range(199, 0) == 0, rn, rc, $urandom_range(9, 0) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
